// File: rtl/display_scan_ctrl_pkg.sv
// Shared codes, segment patterns and helpers for the multiplexed 7-segment scanner.
// Segment patterns are active-high, bit order gfedcba.
package display_scan_ctrl_pkg;

    localparam logic [3:0] CODE_ZERO  = 4'h0;
    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_OFF   = 7'h00;

    // Codes B..F all render as an unlit digit.
    function automatic logic code_is_blank(input logic [3:0] code);
        return (code >= 4'hB);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_seg7_decoder.sv
// Combinational digit-code to active-high gfedcba segment pattern decoder.
module seg7_decoder
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    // Code lookup; every non-digit, non-minus code is blank.
    always_comb begin
        pattern = SEG_OFF;
        case (code)
            4'h0:       pattern = SEG_0;
            4'h1:       pattern = SEG_1;
            4'h2:       pattern = SEG_2;
            4'h3:       pattern = SEG_3;
            4'h4:       pattern = SEG_4;
            4'h5:       pattern = SEG_5;
            4'h6:       pattern = SEG_6;
            4'h7:       pattern = SEG_7;
            4'h8:       pattern = SEG_8;
            4'h9:       pattern = SEG_9;
            CODE_MINUS: pattern = SEG_MINUS;
            default:    pattern = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/mod_counter.sv
// Free-running modulo counter with enable; wrap flags the enabled terminal count.
module mod_counter #(
    parameter int MODULUS = 8,
    parameter int WIDTH   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    assign wrap = en && (count == WIDTH'(MODULUS - 1));

    // Count register, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment driver with dead time, leading-zero blanking
// and a double buffer that only commits new digits at frame boundaries.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*N_DIGITS-1:0] i_upd_data,
    input  logic                  i_upd_valid,
    output logic                  o_upd_ready,
    output logic [N_DIGITS-1:0]   o_an,
    output logic [6:0]            o_seg,
    output logic                  o_frame
);

    localparam int   P_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int   D_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [P_W-1:0]        prescale_s;
    logic [D_W-1:0]        digit_s;
    logic                  tick_s;
    logic                  boundary_s;
    logic                  xfer_s;
    logic                  slot_on_s;
    logic                  leading_s;
    logic [3:0]            scan_code_s;
    logic [3:0]            cur_code_s;
    logic [3:0]            shown_code_s;
    logic [6:0]            pattern_s;
    logic [N_DIGITS-1:0]   blank_mask_s;
    logic [N_DIGITS-1:0]   an_onehot_s;
    logic [6:0]            seg_on_s;

    logic [4*N_DIGITS-1:0] active_r;
    logic [4*N_DIGITS-1:0] pending_r;
    logic                  pending_full_r;
    logic [N_DIGITS-1:0]   an_r;
    logic [6:0]            seg_r;
    logic                  frame_r;

    mod_counter #(.MODULUS(TICK_DIV), .WIDTH(P_W)) u_prescaler (
        .clk   (i_clk),
        .rst   (i_rst),
        .en    (1'b1),
        .count (prescale_s),
        .wrap  (tick_s)
    );

    // Wrap of the digit counter is exactly the frame boundary.
    mod_counter #(.MODULUS(N_DIGITS), .WIDTH(D_W)) u_digit (
        .clk   (i_clk),
        .rst   (i_rst),
        .en    (tick_s),
        .count (digit_s),
        .wrap  (boundary_s)
    );

    assign xfer_s      = i_upd_valid && !pending_full_r;
    assign o_upd_ready = !pending_full_r;

    // Leading-zero mask: scan from the top, zeros blank until a visible non-zero code.
    always_comb begin
        blank_mask_s = '0;
        leading_s    = 1'b1;
        scan_code_s  = CODE_BLANK;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            scan_code_s = active_r[4*k +: 4];
            if (scan_code_s == CODE_ZERO) begin
                blank_mask_s[k] = leading_s;
            end else if (code_is_blank(scan_code_s)) begin
                blank_mask_s[k] = 1'b0;
            end else begin
                leading_s = 1'b0;
            end
        end
    end

    assign cur_code_s   = active_r[4*digit_s +: 4];
    assign shown_code_s = blank_mask_s[digit_s] ? CODE_BLANK : cur_code_s;

    seg7_decoder u_dec (
        .code    (shown_code_s),
        .pattern (pattern_s)
    );

    // Anode and segment drive for the current slot, dark during dead time.
    always_comb begin
        slot_on_s   = (prescale_s >= P_W'(BLANK_CYCLES));
        an_onehot_s = '0;
        seg_on_s    = SEG_OFF;
        if (slot_on_s) begin
            an_onehot_s = N_DIGITS'(1) << digit_s;
            seg_on_s    = pattern_s;
        end else begin
            an_onehot_s = '0;
            seg_on_s    = SEG_OFF;
        end
    end

    // Update handshake and frame-aligned commit of pending into active.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            active_r       <= {N_DIGITS{CODE_BLANK}};
            pending_r      <= '0;
            pending_full_r <= 1'b0;
        end else begin
            if (boundary_s && pending_full_r) begin
                active_r <= pending_r;
            end else begin
                active_r <= active_r;
            end
            if (xfer_s) begin
                pending_r      <= i_upd_data;
                pending_full_r <= 1'b1;
            end else if (boundary_s) begin
                pending_full_r <= 1'b0;
            end else begin
                pending_full_r <= pending_full_r;
            end
        end
    end

    // Registered display outputs with polarity applied.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            an_r    <= {N_DIGITS{INV}};
            seg_r   <= {7{INV}};
            frame_r <= 1'b0;
        end else begin
            an_r    <= an_onehot_s ^ {N_DIGITS{INV}};
            seg_r   <= seg_on_s ^ {7{INV}};
            frame_r <= boundary_s;
        end
    end

    assign o_an    = an_r;
    assign o_seg   = seg_r;
    assign o_frame = frame_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (4 digits, 8-cycle slots, 2 dead cycles, active-low)
// with a cycle model feeding an expected-output scoreboard.
module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int TD = 8;
    localparam int BC = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       frame;
        logic       ready;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] upd_data;
    logic        upd_valid;
    logic        upd_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame;

    int vectors     = 0;
    int miscompares = 0;

    exp_t        sb_q[$];
    int          m_p, m_d;
    logic [15:0] m_active, m_pend;
    bit          m_full;
    bit          frame_now;
    logic [6:0]  seen[N];
    int          low_cnt[N];

    display_scan_ctrl #(
        .N_DIGITS(N), .TICK_DIV(TD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_upd_data  (upd_data),
        .i_upd_valid (upd_valid),
        .o_upd_ready (upd_ready),
        .o_an        (an),
        .o_seg       (seg),
        .o_frame     (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] model_seg(input logic [15:0] act, input int d);
        logic [3:0] c;
        logic [3:0] u;
        bit lead;
        c = act[d*4 +: 4];
        lead = 1'b1;
        for (int k = N - 1; k > d; k--) begin
            u = act[k*4 +: 4];
            if (!(u == 4'h0 || u >= 4'hB)) lead = 1'b0;
        end
        if (d > 0 && c == 4'h0 && lead) return 7'h00;
        case (c)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    task automatic clear_seen();
        for (int k = 0; k < N; k++) begin
            seen[k]    = 7'bxxxxxxx;
            low_cnt[k] = 0;
        end
    endtask

    // One clock: model the edge, push the expectation, then compare the DUT against it.
    task automatic cycle();
        exp_t e;
        exp_t got;
        bit   tick;
        bit   bnd;
        bit   xfer;
        if (rst) begin
            e.an = 4'hF; e.seg = 7'h7F; e.frame = 1'b0; e.ready = 1'b1;
            m_p = 0; m_d = 0; m_active = 16'hFFFF; m_pend = 16'h0000; m_full = 1'b0;
        end else begin
            e.an    = (m_p >= BC) ? ~(4'b0001 << m_d) : 4'hF;
            e.seg   = (m_p >= BC) ? ~model_seg(m_active, m_d) : 7'h7F;
            tick    = (m_p == TD - 1);
            bnd     = tick && (m_d == N - 1);
            e.frame = bnd;
            xfer    = upd_valid && !m_full;
            if (bnd && m_full) begin
                m_active = m_pend;
                m_full   = 1'b0;
            end
            if (xfer) begin
                m_pend = upd_data;
                m_full = 1'b1;
            end
            m_p = tick ? 0 : m_p + 1;
            if (tick) m_d = (m_d + 1) % N;
            e.ready = !m_full;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("sb_an",    32'(an),        32'(got.an));
        check("sb_seg",   32'(seg),       32'(got.seg));
        check("sb_frame", 32'(frame),     32'(got.frame));
        check("sb_ready", 32'(upd_ready), 32'(got.ready));
        check("an_at_most_one", 32'($countones(~an) <= 1), 32'd1);
        frame_now = frame;
        for (int k = 0; k < N; k++) begin
            if (an[k] == 1'b0) begin
                low_cnt[k]++;
                seen[k] = seg;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_frame();
        bit got;
        int n;
        got = 1'b0;
        n   = 0;
        while (!got && n < 100) begin
            cycle();
            got = frame_now;
            n++;
        end
        check("frame_wait", 32'(got), 32'd1);
    endtask

    task automatic send(input logic [15:0] v);
        upd_data  = v;
        upd_valid = 1'b1;
        cycle();
        upd_valid = 1'b0;
        upd_data  = 16'h0000;
    endtask

    task automatic check_digits(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0);
        check({tag, "_d3"}, 32'(seen[3]), 32'(s3));
        check({tag, "_d2"}, 32'(seen[2]), 32'(s2));
        check({tag, "_d1"}, 32'(seen[1]), 32'(s1));
        check({tag, "_d0"}, 32'(seen[0]), 32'(s0));
    endtask

    initial begin
        int frames;
        rst       = 1'b1;
        upd_data  = 16'h0000;
        upd_valid = 1'b0;
        clear_seen();

        // 1: reset state, then two blank frames with one frame pulse each
        cycle();
        rst = 1'b0;
        check("rst_an",    32'(an),        32'h0000000F);
        check("rst_seg",   32'(seg),       32'h0000007F);
        check("rst_ready", 32'(upd_ready), 32'd1);
        check("rst_frame", 32'(frame),     32'd0);
        for (int f = 0; f < 2; f++) begin
            frames = 0;
            for (int i = 0; i < 32; i++) begin
                cycle();
                if (frame_now) frames++;
            end
            check("frame_count", 32'(frames), 32'd1);
        end
        check("frame_last", 32'(frame_now), 32'd1);
        check_digits("blank", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        // 2: update at cycle 5 of a frame, commits at next boundary
        run(5);
        send(16'h0042);
        check("ready_low", 32'(upd_ready), 32'd0);
        clear_seen();
        wait_frame();
        check_digits("pre_commit", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        clear_seen();
        run(32);
        check_digits("v0042", 7'h7F, 7'h7F, 7'h19, 7'h24);
        check("ready_back", 32'(upd_ready), 32'd1);

        // 3: all zeros keeps only digit 0
        send(16'h0000);
        wait_frame();
        clear_seen();
        run(32);
        check_digits("v0000", 7'h7F, 7'h7F, 7'h7F, 7'h40);

        // 4: minus stops blanking, inner zero shown
        send(16'h0A05);
        wait_frame();
        clear_seen();
        run(32);
        check_digits("v0A05", 7'h7F, 7'h3F, 7'h40, 7'h12);

        // 5: second update while pending full is ignored; slot timing
        send(16'h0321);
        send(16'h0999);
        check("ready_full", 32'(upd_ready), 32'd0);
        wait_frame();
        clear_seen();
        run(32);
        check_digits("v0321", 7'h7F, 7'h30, 7'h24, 7'h79);
        for (int k = 0; k < N; k++) check("an_low_cycles", 32'(low_cnt[k]), 32'd6);

        // 6: reset mid-slot with pending full discards everything
        send(16'h0888);
        run(3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_an",    32'(an),        32'h0000000F);
        check("mid_rst_seg",   32'(seg),       32'h0000007F);
        check("mid_rst_ready", 32'(upd_ready), 32'd1);
        check("mid_rst_frame", 32'(frame),     32'd0);
        clear_seen();
        run(64);
        check_digits("post_rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
